// File: rtl/leading_digit_counter_pipe.sv
// rtl/leading_digit_counter_pipe.sv - two-stage pipelined leading-one / leading-zero detector
//
// Finds the most-significant 1 (in_mode=0) or 0 (in_mode=1) of in_data and
// reports whether it exists, its bit index and the count of digits above it.
// A sideband tag travels with each transaction. Two register stages, each
// holding one transaction, with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake
//   in_data            word to scan
//   in_mode            0 = leading one, 1 = leading zero
//   in_tag             sideband, returned unchanged on out_tag
//   out_valid/out_ready output handshake
//   out_found          a matching digit exists
//   out_position       index of the most-significant matching bit (0 if none)
//   out_count          leading non-matching digits (WIDTH if none)
//   out_tag            tag of the same transaction
module leading_digit_counter_pipe #(
  parameter int WIDTH       = 32,
  parameter int GROUP_WIDTH = 8,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_mode,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_found,
  output logic [$clog2(WIDTH)-1:0]   out_position,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic [TAG_WIDTH-1:0]       out_tag
);

  localparam int NG = WIDTH / GROUP_WIDTH;
  localparam int GB = $clog2(GROUP_WIDTH);
  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  logic                 s1_valid;
  logic                 s1_load;
  logic                 s2_load;
  logic [WIDTH-1:0]     scan_word;
  logic [NG-1:0]        g_found;
  logic [GB-1:0]        g_pos [NG];
  logic [NG-1:0]        s1_found;
  logic [GB-1:0]        s1_pos [NG];
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 sel_found;
  logic [CW-1:0]        sel_pos;
  logic [CW-1:0]        sel_count;

  // Each stage advances when its downstream slot is free or being emptied;
  // in_ready is the only combinational path from out_ready.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Leading-zero search is a leading-one search on the inverted word.
  assign scan_word = in_mode ? ~in_data : in_data;

  // Stage 1: per-group presence and local index of the top set bit.
  for (genvar g = 0; g < NG; g++) begin : g_group
    logic [GROUP_WIDTH-1:0] grp;
    logic [GB-1:0]          local_pos;

    assign grp        = scan_word[g*GROUP_WIDTH +: GROUP_WIDTH];
    assign g_found[g] = |grp;
    assign g_pos[g]   = local_pos;

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
      local_pos = '0;
      for (int b = 0; b < GROUP_WIDTH; b++) begin
        if (grp[b]) local_pos = GB'(b);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_found <= '0;
      s1_tag   <= '0;
      for (int g = 0; g < NG; g++) s1_pos[g] <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_found <= g_found;
        s1_tag   <= in_tag;
        for (int g = 0; g < NG; g++) s1_pos[g] <= g_pos[g];
      end
    end
  end

  // Stage 2: pick the highest group that has a hit. Arithmetic is kept at
  // CW bits so count=WIDTH does not wrap for power-of-two widths.
  always_comb begin
    sel_found = 1'b0;
    sel_pos   = '0;
    for (int g = 0; g < NG; g++) begin
      if (s1_found[g]) begin
        sel_found = 1'b1;
        sel_pos   = CW'(g * GROUP_WIDTH) + CW'(s1_pos[g]);
      end
    end
    sel_count = sel_found ? (CW'(WIDTH - 1) - sel_pos) : CW'(WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_found    <= 1'b0;
      out_position <= '0;
      out_count    <= '0;
      out_tag      <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_found    <= sel_found;
        out_position <= sel_pos[PW-1:0];
        out_count    <= sel_count;
        out_tag      <= s1_tag;
      end
    end
  end

endmodule
